// File: rtl/nv_nvdla_cacc_csb_slave.sv
// rtl/nv_nvdla_cacc_csb_slave.sv - CACC CSB register responder with a ping-pong register file
//
// Decodes 63-bit csb2cacc request packets and serves reads and writes on a two-group
// register file. Returns 34-bit cacc2csb response packets, and drives the consumer
// group's configuration to the accumulator datapath.
//
// Ports:
//   nvdla_core_clk, nvdla_core_rstn    clock, asynchronous active-low reset
//   csb2cacc_req_pvld/prdy/pd          request channel (prdy is tied high)
//   cacc2csb_resp_valid/pd             response channel (single-cycle pulse, no backpressure)
//   dp2reg_done                        layer-done pulse from the datapath
//   reg2dp_*                           consumer-group configuration (registered)
//
// Optional feature macro: NVDLA_CACC_CSB_ERR_EN
//   When defined, the response error bit is raised for unmapped offsets and decode misses.
//   It is also raised for an unprivileged write to D_OP_ENABLE, and that write is dropped.

module nv_nvdla_cacc_csb_slave (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        csb2cacc_req_pvld,
    output logic        csb2cacc_req_prdy,
    input  logic [62:0] csb2cacc_req_pd,
    output logic        cacc2csb_resp_valid,
    output logic [33:0] cacc2csb_resp_pd,
    input  logic        dp2reg_done,
    output logic        reg2dp_op_en,
    output logic [31:0] reg2dp_misc_cfg,
    output logic [31:0] reg2dp_dataout_addr,
    output logic [4:0]  reg2dp_clip_truncate
);

    localparam logic [21:0] BASE_WADDR = 22'h2400;

`ifdef NVDLA_CACC_CSB_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    // Request fields
    logic [21:0] req_addr;
    logic [31:0] req_wdat;
    logic        req_write;
    logic        req_nposted;
    logic        req_srcpriv;
    logic [3:0]  req_wrbe;
    logic        unused_level;

    assign req_addr     = csb2cacc_req_pd[21:0];
    assign req_wdat     = csb2cacc_req_pd[53:22];
    assign req_write    = csb2cacc_req_pd[54];
    assign req_nposted  = csb2cacc_req_pd[55];
    assign req_srcpriv  = csb2cacc_req_pd[56];
    assign req_wrbe     = csb2cacc_req_pd[60:57];
    assign unused_level = ^csb2cacc_req_pd[62:61];

    assign csb2cacc_req_prdy = 1'b1;

    // Register state
    logic             producer;
    logic             consumer;
    logic [1:0]       op_en;
    logic [1:0][31:0] misc_cfg;
    logic [1:0][31:0] dataout_addr;
    logic [1:0][4:0]  clip_cfg;

    // Next-state values; the consumer outputs are registered from these so they
    // track consumer toggles and consumer-group writes at the same edge.
    logic             producer_nxt;
    logic             consumer_nxt;
    logic [1:0]       op_en_nxt;
    logic [1:0][31:0] misc_cfg_nxt;
    logic [1:0][31:0] dataout_addr_nxt;
    logic [1:0][4:0]  clip_cfg_nxt;

    logic [9:0]  offset;
    logic        hit;
    logic        mapped;
    logic        wr_en;
    logic        priv_ok;
    logic        locked;
    logic [31:0] be_mask;
    logic [31:0] clip_merged;
    logic [31:0] rd_data;
    logic        err;
    logic        resp_fire;

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    always_comb begin
        offset   = req_addr[9:0];
        hit      = (req_addr[21:10] == BASE_WADDR[21:10]);
        mapped   = hit && (offset <= 10'd5);
        wr_en    = csb2cacc_req_pvld && req_write && mapped;
        // Privilege only matters when error reporting is built in
        priv_ok  = !ERR_EN || req_srcpriv;
        locked   = op_en[producer];
        be_mask  = {{8{req_wrbe[3]}}, {8{req_wrbe[2]}}, {8{req_wrbe[1]}}, {8{req_wrbe[0]}}};
        clip_merged = merge_be({27'd0, clip_cfg[producer]}, req_wdat, be_mask);

        // Read mux samples the current (pre-update) state
        rd_data = 32'd0;
        if (mapped) begin
            case (offset)
                10'd0:   rd_data = {15'd0, op_en[1], 15'd0, op_en[0]};
                10'd1:   rd_data = {15'd0, consumer, 15'd0, producer};
                10'd2:   rd_data = {31'd0, op_en[producer]};
                10'd3:   rd_data = misc_cfg[producer];
                10'd4:   rd_data = dataout_addr[producer];
                10'd5:   rd_data = {27'd0, clip_cfg[producer]};
                default: rd_data = 32'd0;
            endcase
        end

        err = ERR_EN && (!mapped || (req_write && offset == 10'd2 && !req_srcpriv));

        producer_nxt     = producer;
        consumer_nxt     = consumer;
        op_en_nxt        = op_en;
        misc_cfg_nxt     = misc_cfg;
        dataout_addr_nxt = dataout_addr;
        clip_cfg_nxt     = clip_cfg;

        if (dp2reg_done) begin
            op_en_nxt[consumer] = 1'b0;
            consumer_nxt        = ~consumer;
        end

        if (wr_en) begin
            case (offset)
                10'd1: if (req_wrbe[0]) producer_nxt = req_wdat[0];
                // Applied after the done clear so a same-cycle set wins
                10'd2: if (req_wrbe[0] && req_wdat[0] && priv_ok) op_en_nxt[producer] = 1'b1;
                10'd3: if (!locked) misc_cfg_nxt[producer] =
                           merge_be(misc_cfg[producer], req_wdat, be_mask);
                10'd4: if (!locked) dataout_addr_nxt[producer] =
                           merge_be(dataout_addr[producer], req_wdat, be_mask);
                10'd5: if (!locked) clip_cfg_nxt[producer] = clip_merged[4:0];
                default: ;
            endcase
        end

        resp_fire = csb2cacc_req_pvld && (!req_write || req_nposted);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            producer             <= 1'b0;
            consumer             <= 1'b0;
            op_en                <= '0;
            misc_cfg             <= '0;
            dataout_addr         <= '0;
            clip_cfg             <= '0;
            cacc2csb_resp_valid  <= 1'b0;
            cacc2csb_resp_pd     <= 34'd0;
            reg2dp_op_en         <= 1'b0;
            reg2dp_misc_cfg      <= 32'd0;
            reg2dp_dataout_addr  <= 32'd0;
            reg2dp_clip_truncate <= 5'd0;
        end else begin
            producer             <= producer_nxt;
            consumer             <= consumer_nxt;
            op_en                <= op_en_nxt;
            misc_cfg             <= misc_cfg_nxt;
            dataout_addr         <= dataout_addr_nxt;
            clip_cfg             <= clip_cfg_nxt;
            cacc2csb_resp_valid  <= resp_fire;
            if (resp_fire) begin
                cacc2csb_resp_pd <= {req_write, err, req_write ? 32'd0 : rd_data};
            end
            reg2dp_op_en         <= op_en_nxt[consumer_nxt];
            reg2dp_misc_cfg      <= misc_cfg_nxt[consumer_nxt];
            reg2dp_dataout_addr  <= dataout_addr_nxt[consumer_nxt];
            reg2dp_clip_truncate <= clip_cfg_nxt[consumer_nxt];
        end
    end

endmodule

// File: tb/tb_nv_nvdla_cacc_csb_slave.sv
// tb/tb_nv_nvdla_cacc_csb_slave.sv - scoreboard testbench for nv_nvdla_cacc_csb_slave

module tb_nv_nvdla_cacc_csb_slave;

    localparam logic [21:0] BASE = 22'h2400;
`ifdef NVDLA_CACC_CSB_ERR_EN
    localparam logic E = 1'b1;
`else
    localparam logic E = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_pvld = 1'b0;
    logic        req_prdy;
    logic [62:0] req_pd = '0;
    logic        resp_valid;
    logic [33:0] resp_pd;
    logic        done = 1'b0;
    logic        op_en;
    logic [31:0] misc_cfg;
    logic [31:0] dataout_addr;
    logic [4:0]  clip;

    int n_checks = 0;
    int n_fail   = 0;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    nv_nvdla_cacc_csb_slave dut (
        .nvdla_core_clk       (clk),
        .nvdla_core_rstn      (rst_n),
        .csb2cacc_req_pvld    (req_pvld),
        .csb2cacc_req_prdy    (req_prdy),
        .csb2cacc_req_pd      (req_pd),
        .cacc2csb_resp_valid  (resp_valid),
        .cacc2csb_resp_pd     (resp_pd),
        .dp2reg_done          (done),
        .reg2dp_op_en         (op_en),
        .reg2dp_misc_cfg      (misc_cfg),
        .reg2dp_dataout_addr  (dataout_addr),
        .reg2dp_clip_truncate (clip)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every response is compared against the oldest expectation
    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) check_eq("unexpected_resp", {30'd0, resp_pd}, 64'h0);
            else check_eq("resp_pd", {30'd0, resp_pd}, {30'd0, exp_q.pop_front()});
        end
    end

    // Drive one request for one cycle; called #1 after a rising edge
    task automatic issue(input logic w, input logic np, input logic priv, input logic [3:0] be,
                         input logic [21:0] addr, input logic [31:0] d, input logic with_done);
        req_pvld = 1'b1;
        req_pd   = {2'b00, be, priv, np, w, d, addr};
        done     = with_done;
        @(posedge clk);
        #1;
        req_pvld = 1'b0;
        done     = 1'b0;
    endtask

    task automatic rd(input logic [9:0] off, input logic [31:0] exp);
        exp_q.push_back({1'b0, 1'b0, exp});
        issue(1'b0, 1'b0, 1'b1, 4'hF, BASE + {12'd0, off}, 32'd0, 1'b0);
    endtask

    task automatic wr_np(input logic [9:0] off, input logic [31:0] d, input logic [3:0] be);
        exp_q.push_back({1'b1, 1'b0, 32'd0});
        issue(1'b1, 1'b1, 1'b1, be, BASE + {12'd0, off}, d, 1'b0);
    endtask

    task automatic wr_p(input logic [9:0] off, input logic [31:0] d, input logic [3:0] be);
        issue(1'b1, 1'b0, 1'b1, be, BASE + {12'd0, off}, d, 1'b0);
    endtask

    task automatic pulse_done;
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
    endtask

    task automatic check_dp(input string tag, input logic e_op, input logic [31:0] e_misc,
                            input logic [31:0] e_addr, input logic [4:0] e_clip);
        check_eq({tag, "_op_en"}, {63'd0, op_en}, {63'd0, e_op});
        check_eq({tag, "_misc"}, {32'd0, misc_cfg}, {32'd0, e_misc});
        check_eq({tag, "_addr"}, {32'd0, dataout_addr}, {32'd0, e_addr});
        check_eq({tag, "_clip"}, {59'd0, clip}, {59'd0, e_clip});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("prdy_in_reset", {63'd0, req_prdy}, 64'd1);
        check_eq("resp_valid_reset", {63'd0, resp_valid}, 64'd0);
        check_eq("resp_pd_reset", {30'd0, resp_pd}, 64'd0);
        check_dp("reset", 1'b0, 32'd0, 32'd0, 5'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        rd(10'h1, 32'h0);

        // Byte-enable merge, back-to-back write then read
        wr_np(10'h3, 32'hDEADBEEF, 4'b0101);
        rd(10'h3, 32'h00AD00EF);
        check_eq("dp_misc_after_wr", {32'd0, misc_cfg}, {32'd0, 32'h00AD00EF});
        wr_p(10'h4, 32'h11223344, 4'hF);
        wr_p(10'h5, 32'hFFFFFFFF, 4'hF);
        rd(10'h5, 32'h0000001F);
        check_dp("grp0_prog", 1'b0, 32'h00AD00EF, 32'h11223344, 5'h1F);

        // Enable group 0, then locked write is dropped
        wr_np(10'h2, 32'h1, 4'hF);
        check_eq("op_en_set", {63'd0, op_en}, 64'd1);
        rd(10'h0, 32'h00000001);
        rd(10'h2, 32'h00000001);
        wr_np(10'h3, 32'h12345678, 4'hF);
        rd(10'h3, 32'h00AD00EF);

        // Program group 1 while group 0 is being consumed
        wr_np(10'h1, 32'h1, 4'hF);
        wr_p(10'h3, 32'hCAFEF00D, 4'hF);
        wr_p(10'h4, 32'hA5A5A5A5, 4'hF);
        wr_p(10'h5, 32'h00000003, 4'hF);
        wr_p(10'h2, 32'h1, 4'hF);
        check_dp("hold_grp0", 1'b1, 32'h00AD00EF, 32'h11223344, 5'h1F);
        rd(10'h0, 32'h00010001);
        rd(10'h1, 32'h00000001);

        pulse_done();
        check_dp("switch_grp1", 1'b1, 32'hCAFEF00D, 32'hA5A5A5A5, 5'h03);
        rd(10'h1, 32'h00010001);
        rd(10'h0, 32'h00010000);

        // Read in the done cycle sees pre-done pointers
        exp_q.push_back({1'b0, 1'b0, 32'h00010001});
        issue(1'b0, 1'b0, 1'b1, 4'hF, BASE + 22'h1, 32'd0, 1'b1);
        check_dp("back_grp0", 1'b0, 32'h00AD00EF, 32'h11223344, 5'h1F);

        // Set and done on group 0 in the same cycle: set wins, consumer still toggles
        wr_np(10'h1, 32'h0, 4'hF);
        exp_q.push_back({1'b1, 1'b0, 32'd0});
        issue(1'b1, 1'b1, 1'b1, 4'hF, BASE + 22'h2, 32'h1, 1'b1);
        check_dp("set_wins", 1'b0, 32'hCAFEF00D, 32'hA5A5A5A5, 5'h03);
        rd(10'h0, 32'h00000001);
        rd(10'h1, 32'h00010000);

        // Error reporting
        exp_q.push_back({1'b1, E, 32'd0});
        issue(1'b1, 1'b1, 1'b0, 4'hF, BASE + 22'h2, 32'h1, 1'b0);
        exp_q.push_back({1'b0, E, 32'd0});
        issue(1'b0, 1'b0, 1'b1, 4'hF, BASE + 22'h3F, 32'd0, 1'b0);
        exp_q.push_back({1'b0, E, 32'd0});
        issue(1'b0, 1'b0, 1'b1, 4'hF, 22'h0003, 32'd0, 1'b0);

        // Reset while a response is pending
        req_pvld = 1'b1;
        req_pd   = {2'b00, 4'hF, 1'b1, 1'b0, 1'b0, 32'd0, BASE + 22'h1};
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        req_pvld = 1'b0;
        @(negedge clk);
        check_eq("resp_cleared_by_reset", {63'd0, resp_valid}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_dp("after_reset", 1'b0, 32'd0, 32'd0, 5'd0);
        rd(10'h1, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check_eq("scoreboard_drained", exp_q.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_cacc_csb_slave.md
# nv_nvdla_cacc_csb_slave

CSB register responder at the CACC end of the csb2cacc link. It sits downstream of the csb2cacc request retiming pipe and upstream of the cacc2csb response pipe. It decodes each 63-bit request packet and performs the read or write on a ping-pong (two-group) register file. It returns a 34-bit response packet and drives the consumer group's configuration to the accumulator datapath.

## Interface
- BASE_WADDR, 22'h2400: word address of register offset 0; decode on addr[21:10] == BASE_WADDR[21:10].
- nvdla_core_clk  in  1  core clock; single clock domain.
- nvdla_core_rstn  in  1  asynchronous active-low reset. All state clears on assertion; release is synchronous to nvdla_core_clk.
- csb2cacc_req_pvld  in  1  request valid.
- csb2cacc_req_prdy  out  1  tied 1'b1. Every valid request is accepted in its cycle.
- csb2cacc_req_pd  in  63  request fields:
  - addr[21:0], word address
  - wdat[53:22]
  - write[54]
  - nposted[55]
  - srcpriv[56]
  - wrbe[60:57]
  - level[62:61]
- cacc2csb_resp_valid  out  1  response valid, one-cycle pulse per response; no backpressure.
- cacc2csb_resp_pd  out  34  response fields:
  - [33] type: 0 read, 1 write
  - [32] error
  - [31:0] read data; 0 for writes
- dp2reg_done  in  1  single-cycle pulse: the datapath finished the consumer group's layer.
- reg2dp_op_en  out  1  op_en of the consumer group.
- reg2dp_misc_cfg  out  32  consumer-group D_MISC_CFG.
- reg2dp_dataout_addr  out  32  consumer-group D_DATAOUT_ADDR.
- reg2dp_clip_truncate  out  5  consumer-group D_CLIP_CFG[4:0].

## Operation
Register map (word offset = addr - BASE_WADDR):
- 0x0 S_STATUS (RO)
  - [1:0]: group 0 status; 0 idle, 1 enabled
  - [17:16]: group 1 status, same encoding
- 0x1 S_POINTER
  - [0] producer (RW)
  - [16] consumer (RO)
- 0x2 D_OP_ENABLE [0], group register
- 0x3 D_MISC_CFG [31:0], group register
- 0x4 D_DATAOUT_ADDR [31:0], group register
- 0x5 D_CLIP_CFG [4:0], group register
- Group registers (D_*) exist twice. Reads and writes target the group selected by producer.
- Writes apply byte enables wrbe[3:0] per byte lane. Bits outside the implemented field are ignored on write and read back as 0.
- Writing 1 to D_OP_ENABLE bit 0 sets op_en[producer]; writing 0 has no effect.
- Group lock: while op_en[g]=1, writes to D_MISC_CFG, D_DATAOUT_ADDR and D_CLIP_CFG of group g are dropped. The dropped write is not an error.
- Writes to RO fields are ignored without error.
- dp2reg_done: clears op_en[consumer] and toggles consumer, both in the same cycle.
- Simultaneous set of op_en[g] by write and clear of op_en[g] by done: the set wins and op_en[g] ends at 1. The consumer still toggles.
- Response rules:
  - Read: always responds; type=0, data = the addressed value sampled in the request cycle.
  - Write with nposted=1: responds with type=1, data=0.
  - Write with nposted=0: no response.
  - Unmapped offset or decode miss: read data=0, write has no effect, error per Configuration.

## Timing
- Request accepted in cycle N. Register update and consumer outputs take effect at edge N+1. cacc2csb_resp_valid is high during cycle N+1.
- Back-to-back requests every cycle are supported, giving one response per cycle. A read in cycle N+1 sees the write from cycle N.
- A read in the same cycle as dp2reg_done returns the pre-done values.
- reg2dp_* are registered and follow consumer changes at the same edge.
- Reset values: resp_valid=0, resp_pd=0, all registers 0, producer=0, consumer=0, reg2dp_*=0. prdy=1 during reset.
- Reset asserted mid-operation clears any pending response; no response is emitted after reset release.

## Configuration
- NVDLA_CACC_CSB_ERR_EN defined: the error bit is set for unmapped offsets and decode misses. It is also set for a write with srcpriv=0 to D_OP_ENABLE, and that write is dropped.
- NVDLA_CACC_CSB_ERR_EN undefined: the error bit is always 0 and srcpriv is ignored.

## Test plan
- Reset, then read offset 0x1 -> resp_pd = {1'b0, 1'b0, 32'h0} one cycle later; all reg2dp_* = 0.
- Nposted write of 0xDEADBEEF to 0x3 with wrbe=4'b0101, then read 0x3 -> reads 0x00AD00EF; write resp_pd[33]=1. Posted write -> no resp_valid.
- Write 1 to 0x2 in group 0 -> reg2dp_op_en=1. A later write to 0x3 group 0 is dropped. Pulse dp2reg_done -> op_en 0, consumer=1, S_POINTER[16]=1.
- Set producer=1, program group 1 while group 0 is enabled -> reg2dp_* keep group 0 values until done, then switch to group 1 at the next edge.
- Write op_en group 0 in the same cycle as dp2reg_done with consumer=0 -> op_en[0] stays 1, consumer=1.
- Read offset 0x3F with NVDLA_CACC_CSB_ERR_EN defined -> resp_pd[32]=1, data 0. With the macro undefined -> resp_pd[32]=0.
